// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes 32-bit words into instruction memory,
// checks the XOR trailer and releases the MIPS core from reset on success.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Stream handshake: a byte moves only on a rising edge where in_valid and in_ready are both 1;
  // in_valid may drop at any time and a byte offered while in_ready=0 stays with the source.

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_WORD, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [7:0]          xor_q, xor_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic [15:0]         hdr_count;
  logic                accept;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count_q[15:8], in_data};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HDR_HI;
      count_q        <= '0;
      xor_q          <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      words_loaded_q <= '0;
      im_addr_q      <= BASE;
      im_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      xor_q          <= xor_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
      im_addr_q      <= im_addr_d;
      im_wdata_q     <= im_wdata_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    xor_d          = xor_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    im_addr_d      = im_addr_q;
    im_wdata_d     = im_wdata_q;
    case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = in_data;
          xor_d         = xor_q ^ in_data;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          xor_d        = xor_q ^ in_data;
          byte_idx_d   = '0;
          if ({1'b0, hdr_count} > MAX_WORDS) state_d = S_ERR;
          else if (hdr_count == 16'd0)       state_d = S_CHK;
          else                               state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (accept) begin
          word_d     = {word_q[15:0], in_data};
          xor_d      = xor_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch the write port now so it is stable for the whole WRITE cycle and holds after.
            im_addr_d  = BASE + words_loaded_q[ADDR_W-1:0];
            im_wdata_d = {word_q, in_data};
            state_d    = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
        if (32'(words_loaded_q) + 32'd1 == 32'(count_q)) state_d = S_CHK;
        else                                             state_d = S_WORD;
      end
      S_CHK: begin
        if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    im_we     = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst_n = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_WORD, S_CHK: in_ready = !rst;
      S_WRITE: im_we = 1'b1;
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign words_loaded = words_loaded_q;

endmodule
